// File: rtl/pc_gen_bp_pkg.sv
// Shared types and defaults for the fetch-PC generator and its BTB.
package pc_gen_bp_pkg;

  localparam int          DEF_XLEN     = 64;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic ctr_e sat_inc(ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e sat_dec(ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_gen_bp_if.sv
// Fetch-PC handshake toward IF, carrying the prediction for the offered PC.
interface pc_gen_bp_if
  import pc_gen_bp_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);

  logic            pc_valid;
  logic            pc_ready;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output pc_valid,
    output pc,
    output pred_taken,
    output pred_target,
    input  pc_ready
  );

  modport slave (
    input  pc_valid,
    input  pc,
    input  pred_taken,
    input  pred_target,
    output pc_ready
  );

endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped BTB with 2-bit counters; lookup reads pre-update state.
module pc_gen_btb
  import pc_gen_bp_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int DEPTH = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_hit,
  output ctr_e            lk_ctr,
  output logic [XLEN-1:0] lk_target,
  input  logic            up_en,
  input  logic [XLEN-1:0] up_pc,
  input  logic            up_taken,
  input  logic [XLEN-1:0] up_target
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [TAG_W-1:0] tag_d    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [XLEN-1:0]  target_d [DEPTH];
  ctr_e             ctr_q    [DEPTH];
  ctr_e             ctr_d    [DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic             unused_lo;

  assign lk_idx    = lk_pc[IDX_W+1:2];
  assign lk_tag    = lk_pc[XLEN-1:IDX_W+2];
  assign up_idx    = up_pc[IDX_W+1:2];
  assign up_tag    = up_pc[XLEN-1:IDX_W+2];
  assign unused_lo = ^{lk_pc[1:0], up_pc[1:0]};

  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_ctr    = ctr_q[lk_idx];
  assign lk_target = target_q[lk_idx];
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (up_en) begin
      if (up_taken) begin
        // a miss allocates over whatever alias lived here
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = up_target;
        ctr_d[up_idx]    = up_hit ? sat_inc(ctr_q[up_idx]) : WT;
      end else if (up_hit) begin
        ctr_d[up_idx]    = sat_dec(ctr_q[up_idx]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clock) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

endmodule

// File: rtl/pc_gen_bp.sv
// Fetch-PC generator: redirect priority mux, PC register, BTB prediction.
module pc_gen_bp
  import pc_gen_bp_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter int              BTB_DEPTH = 16,
  parameter bit              BTB_EN    = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  pc_gen_bp_if.master     fetch,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_is_br,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_mispred
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic [XLEN-1:0] pc_plus4, nxt;
  logic            lk_hit;
  ctr_e            lk_ctr;
  logic [XLEN-1:0] lk_target;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  pc_gen_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clock     (clock),
    .reset     (reset),
    .lk_pc     (pc_q),
    .lk_hit    (lk_hit),
    .lk_ctr    (lk_ctr),
    .lk_target (lk_target),
    .up_en     (res_valid & res_is_br),
    .up_pc     (res_pc),
    .up_taken  (res_taken),
    .up_target (res_target)
  );

  assign pc_plus4    = pc_q + XLEN'(4);
  assign pred_taken  = BTB_EN && lk_hit && (lk_ctr inside {WT, ST});
  assign pred_target = pred_taken ? lk_target : pc_plus4;

  always_comb begin
    nxt = pc_q;
    if (trap_valid)                    nxt = trap_pc;
    else if (res_valid && res_mispred) nxt = res_target;
    else if (pc_valid_q && fetch.pc_ready) nxt = pred_target;
    pc_d       = nxt & ~XLEN'(1);
    pc_valid_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign fetch.pc_valid    = pc_valid_q;
  assign fetch.pc          = pc_q;
  assign fetch.pred_taken  = pred_taken;
  assign fetch.pred_target = pred_target;

endmodule

// File: tb/tb_pc_gen_bp.sv
// Directed + random bench for pc_gen_bp against a behavioural model.
module tb_pc_gen_bp;

  localparam int          XLEN   = 64;
  localparam int          DEPTH  = 16;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        trap_valid;
  logic [63:0] trap_pc;
  logic        res_valid;
  logic [63:0] res_pc;
  logic        res_is_br;
  logic        res_taken;
  logic [63:0] res_target;
  logic        res_mispred;

  int tests = 0;
  int fails = 0;
  bit known = 0;

  // model state
  logic [63:0] m_pc;
  bit          m_pv;
  bit          mv   [DEPTH];
  logic [63:0] mtag [DEPTH];
  logic [63:0] mtgt [DEPTH];
  int          mctr [DEPTH];

  always #5 clock = ~clock;

  pc_gen_bp_if #(.XLEN(XLEN)) fi ();

  pc_gen_bp #(
    .XLEN      (XLEN),
    .RESET_PC  (RST_PC),
    .BTB_DEPTH (DEPTH),
    .BTB_EN    (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch       (fi.master),
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .res_valid   (res_valid),
    .res_pc      (res_pc),
    .res_is_br   (res_is_br),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .res_mispred (res_mispred)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(logic [63:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [63:0] tag_of(logic [63:0] a);
    return a / (4 * DEPTH);
  endfunction

  task automatic model_pred(output bit tk, output logic [63:0] tgt);
    int i;
    i   = idx_of(m_pc);
    tk  = mv[i] && (mtag[i] == tag_of(m_pc)) && (mctr[i] >= 2);
    tgt = tk ? mtgt[i] : m_pc + 64'd4;
  endtask

  task automatic tick();
    bit          ptk;
    logic [63:0] ptgt;
    logic [63:0] nxt;
    bit          hit;
    int          i;
    @(negedge clock);
    model_pred(ptk, ptgt);
    if (known) begin
      chk("pc_valid", {63'd0, fi.pc_valid}, {63'd0, m_pv});
      chk("pc", fi.pc, m_pc);
      chk("pred_taken", {63'd0, fi.pred_taken}, {63'd0, ptk});
      chk("pred_target", fi.pred_target, ptgt);
    end
    if (reset) begin
      m_pc = RST_PC;
      m_pv = 0;
      for (int k = 0; k < DEPTH; k++) mv[k] = 0;
    end else begin
      if (trap_valid)                         nxt = trap_pc;
      else if (res_valid && res_mispred)      nxt = res_target;
      else if (m_pv && fi.pc_ready)           nxt = ptgt;
      else                                    nxt = m_pc;
      nxt[0] = 1'b0;
      if (res_valid && res_is_br) begin
        i   = idx_of(res_pc);
        hit = mv[i] && (mtag[i] == tag_of(res_pc));
        if (res_taken) begin
          mctr[i] = hit ? ((mctr[i] < 3) ? mctr[i] + 1 : 3) : 2;
          mv[i]   = 1;
          mtag[i] = tag_of(res_pc);
          mtgt[i] = res_target;
        end else if (hit) begin
          mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
        end
      end
      m_pc = nxt;
      m_pv = 1;
    end
    @(posedge clock);
    #1;
    if (reset) known = 1;
  endtask

  task automatic idle();
    trap_valid  = 0;
    trap_pc     = '0;
    res_valid   = 0;
    res_pc      = '0;
    res_is_br   = 0;
    res_taken   = 0;
    res_target  = '0;
    res_mispred = 0;
  endtask

  task automatic redirect(logic [63:0] t);
    res_valid   = 1;
    res_is_br   = 0;
    res_mispred = 1;
    res_target  = t;
    tick();
    idle();
  endtask

  task automatic train(logic [63:0] p, bit tk, logic [63:0] t);
    res_valid   = 1;
    res_is_br   = 1;
    res_pc      = p;
    res_taken   = tk;
    res_target  = t;
    res_mispred = 0;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset       = 1;
    fi.pc_ready = 0;
    repeat (3) tick();
    reset = 0;
    chk("rst_pc", fi.pc, RST_PC);
    chk("rst_valid", {63'd0, fi.pc_valid}, 64'd0);
    chk("rst_pred", {63'd0, fi.pred_taken}, 64'd0);
    chk("rst_tgt", fi.pred_target, RST_PC + 64'd4);
    fi.pc_ready = 1;
    tick();
    chk("valid_rise", {63'd0, fi.pc_valid}, 64'd1);
    chk("pc0", fi.pc, 64'h8000_0000);
    tick();
    chk("pc4", fi.pc, 64'h8000_0004);
    tick();
    chk("pc8", fi.pc, 64'h8000_0008);

    fi.pc_ready = 0;
    repeat (4) tick();
    chk("stall", fi.pc, 64'h8000_0008);
    fi.pc_ready = 1;
    tick();
    chk("pcc", fi.pc, 64'h8000_000c);

    trap_valid = 1;
    trap_pc    = 64'h8000_1000;
    redirect(64'h8000_0200);
    chk("trap_wins", fi.pc, 64'h8000_1000);

    fi.pc_ready = 0;
    train(64'h8000_0010, 1, 64'h8000_0100);
    train(64'h8000_0010, 1, 64'h8000_0100);
    redirect(64'h8000_0010);
    chk("trained_tk", {63'd0, fi.pred_taken}, 64'd1);
    chk("trained_tgt", fi.pred_target, 64'h8000_0100);
    fi.pc_ready = 1;
    tick();
    chk("pred_jump", fi.pc, 64'h8000_0100);
    fi.pc_ready = 0;
    train(64'h8000_0010, 0, 64'h8000_0014);
    train(64'h8000_0010, 0, 64'h8000_0014);
    redirect(64'h8000_0010);
    chk("untrained_tk", {63'd0, fi.pred_taken}, 64'd0);
    fi.pc_ready = 1;
    tick();
    chk("fallthru", fi.pc, 64'h8000_0014);

    fi.pc_ready = 0;
    train(64'h8000_0010, 1, 64'h8000_0100);
    redirect(64'h8000_0050);
    chk("alias_tk", {63'd0, fi.pred_taken}, 64'd0);
    chk("alias_tgt", fi.pred_target, 64'h8000_0054);
    redirect(64'h8000_0010);
    chk("wt_tk", {63'd0, fi.pred_taken}, 64'd1);
    fi.pc_ready = 1;
    res_valid   = 1;
    res_is_br   = 1;
    res_pc      = 64'h8000_0010;
    res_taken   = 0;
    res_target  = 64'h8000_0014;
    tick();
    idle();
    chk("rbw_old", fi.pc, 64'h8000_0100);
    fi.pc_ready = 0;
    redirect(64'h8000_0010);
    chk("rbw_new", {63'd0, fi.pred_taken}, 64'd0);

    fi.pc_ready = 1;
    train(64'h8000_0010, 1, 64'h8000_0100);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_pc", fi.pc, RST_PC);
    chk("mid_rst_v", {63'd0, fi.pc_valid}, 64'd0);
    fi.pc_ready = 0;
    tick();
    redirect(64'h8000_0010);
    chk("empty_btb", {63'd0, fi.pred_taken}, 64'd0);
    redirect(64'h8000_0103);
    chk("bit0_clr", fi.pc, 64'h8000_0102);

    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      fi.pc_ready = ($urandom_range(0, 3) != 0);
      trap_valid  = ($urandom_range(0, 19) == 0);
      trap_pc     = RST_PC + 64'(4 * $urandom_range(0, 63))
                  + 64'($urandom_range(0, 1));
      res_valid   = ($urandom_range(0, 2) == 0);
      res_pc      = ($urandom_range(0, 3) == 0) ? m_pc
                  : RST_PC + 64'(4 * $urandom_range(0, 63));
      res_is_br   = ($urandom_range(0, 3) != 0);
      res_taken   = $urandom_range(0, 1) == 1;
      res_target  = RST_PC + 64'(4 * $urandom_range(0, 63))
                  + 64'($urandom_range(0, 1));
      res_mispred = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 0;
    idle();
    trap_valid = 1;
    trap_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    idle();
    fi.pc_ready = 1;
    tick();
    chk("wrap", fi.pc, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
